// File: rtl/byte_bus_pkg.sv
// Shared types and widths for the 16-bit core to 8-bit memory bridge.
package byte_bus_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/byte_bus_bridge.sv
// Splits 16-bit word requests into two little-endian byte accesses.
// Optional macro BYTE_BUS_BRIDGE_ALIGN_CHK_EN rejects odd word addresses.
module byte_bus_bridge
    import byte_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [WORD_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [BYTE_W-1:0] mem_rdata
);

    bridge_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [WORD_W-1:0] r_addr, w_addr_nxt;
    logic [WORD_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_wen, w_wen_nxt;
    logic [BYTE_W-1:0] r_lo, w_lo_nxt;
    logic [WORD_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_req_ready, r_rsp_valid, r_rsp_err, r_mem_wen;
    logic [WORD_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [BYTE_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              w_mem_wen_nxt, w_err_nxt;
    logic              w_last, w_last_nxt, w_misalign;

    assign w_last = (r_cnt == CNT_W'(WAIT_CYC));

`ifdef BYTE_BUS_BRIDGE_ALIGN_CHK_EN
    assign w_misalign = req_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state plus the values every registered output takes in that state.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wen_nxt       = r_wen;
        w_lo_nxt        = r_lo;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_err_nxt       = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_mem_wen_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                    w_wen_nxt   = req_wen;
                    w_cnt_nxt   = '0;
                    if (w_misalign) begin
                        w_state_nxt = RESP;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = LO;
                    end
                end
            end
            LO: begin
                if (w_last) begin
                    w_state_nxt = HI;
                    w_cnt_nxt   = '0;
                    if (!r_wen) w_lo_nxt = mem_rdata;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HI: begin
                if (w_last) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = '0;
                    if (!r_wen) w_rsp_rdata_nxt = {mem_rdata, r_lo};
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_last_nxt = (w_cnt_nxt == CNT_W'(WAIT_CYC));
        case (w_state_nxt)
            LO: begin
                w_mem_addr_nxt  = w_addr_nxt;
                w_mem_wdata_nxt = w_wen_nxt ? w_wdata_nxt[BYTE_W-1:0] : '0;
                w_mem_wen_nxt   = w_wen_nxt & w_last_nxt;
            end
            HI: begin
                w_mem_addr_nxt  = WORD_W'(w_addr_nxt + WORD_W'(1));
                w_mem_wdata_nxt = w_wen_nxt ? w_wdata_nxt[WORD_W-1:BYTE_W] : '0;
                w_mem_wen_nxt   = w_wen_nxt & w_last_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_lo        <= '0;
            r_rsp_rdata <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wen   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wen       <= w_wen_nxt;
            r_lo        <= w_lo_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_rsp_err   <= w_err_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wen   <= w_mem_wen_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wen   = r_mem_wen;

endmodule
